// File: rtl/param_universal_shift_reg.sv
// param_universal_shift_reg: universal shift register that runs multi-step shift/rotate commands over a handshake
module param_universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] pdata_in,
    input  logic             sin,
    output logic [WIDTH-1:0] pdata_out,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [2:0] LOAD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3, ROR = 3'd4;
    logic [1:0]       state;
    logic [2:0]       op;
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] q, nq;
    logic             sout_r, err_r, nsout;
    always_comb begin
        nq = op == SHL ? {q[WIDTH-2:0], sin} :
             op == SHR ? {sin, q[WIDTH-1:1]} :
             op == ROL ? {q[WIDTH-2:0], q[WIDTH-1]} :
             op == ROR ? {q[0], q[WIDTH-1:1]} :
                         {q[WIDTH-1], q[WIDTH-1:1]};
        nsout = (op == SHL || op == ROL) ? q[WIDTH-1] : q[0];
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            op     <= LOAD;
            rem    <= '0;
            q      <= '0;
            sout_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op    <= cmd_op;
                    err_r <= cmd_op > 3'd5;
                    rem   <= cmd_cnt;
                    if (cmd_op == LOAD)
                        q <= pdata_in;
                    // LOAD, illegal ops and zero-step shifts all finish without stepping
                    state <= (cmd_op == LOAD || cmd_op > 3'd5 || cmd_cnt == '0) ? DONE : SHIFT;
                end
                SHIFT: begin
                    q      <= nq;
                    sout_r <= nsout;
                    rem    <= rem - 1'b1;
                    if (rem == CNT_W'(1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign cmd_ready = state == IDLE;
    assign busy      = !cmd_ready;
    assign done      = state == DONE;
    assign err       = done && err_r;
    assign pdata_out = q;
    assign sout      = sout_r;
endmodule

// File: tb/tb_param_universal_shift_reg.sv
// tb_param_universal_shift_reg: table vectors, corner sequences and random commands against an arithmetic model
module tb_param_universal_shift_reg;
    localparam int W = 8;
    localparam int C = 4;
    logic clk = 1'b0;
    logic clear, cmd_valid, sin, cmd_ready, sout, busy, done, err;
    logic [2:0] cmd_op;
    logic [C-1:0] cmd_cnt;
    logic [W-1:0] pdata_in, pdata_out;
    int errs = 0, checks = 0;
    int mq = 0, msout = 0;

    param_universal_shift_reg #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .pdata_in(pdata_in), .sin(sin),
        .pdata_out(pdata_out), .sout(sout), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        int op; int cnt; int data; int sv; int eq; int es; int ee;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One step of the register, as integer arithmetic on a value in 0..2**W-1
    function automatic void mstep(input int o, input int s);
        int top, bot;
        top = mq / (2 ** (W - 1));
        bot = mq % 2;
        msout = (o == 1 || o == 3) ? top : bot;
        case (o)
            1: mq = (mq * 2 + s) % (2 ** W);
            2: mq = mq / 2 + s * 2 ** (W - 1);
            3: mq = (mq * 2 + top) % (2 ** W);
            4: mq = mq / 2 + bot * 2 ** (W - 1);
            default: mq = mq / 2 + top * 2 ** (W - 1);
        endcase
    endfunction

    task automatic run_cmd(input int op, input int cnt, input int data, input int sv, output logic got_err);
        int n, w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            tick;
            w++;
        end
        chk("ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = 3'(op);
        cmd_cnt = C'(cnt);
        pdata_in = W'(data);
        tick;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_cnt = C'($urandom);
        pdata_in = W'($urandom);
        n = (op >= 1 && op <= 5) ? cnt : 0;
        if (op == 0) mq = data;
        for (int i = 0; i < n; i++) begin
            chk("busy_in_shift", {busy, done, cmd_ready}, 3'b100);
            chk("q_mid_shift", pdata_out, mq);
            sin = sv < 0 ? 1'($urandom) : 1'(sv);
            mstep(op, int'(sin));
            tick;
        end
        chk("done_pulse", {busy, done, cmd_ready}, 3'b110);
        chk("q_at_done", pdata_out, mq);
        chk("sout_at_done", sout, msout);
        chk("err_at_done", err, op > 5);
        got_err = err;
        tick;
        chk("idle_after_done", {cmd_ready, busy, done, err}, 4'b1000);
    endtask

    initial begin
        logic e;
        tbl[0]  = '{0, 0, 'hA5, 0, 'hA5, 0, 0};
        tbl[1]  = '{0, 0, 'h81, 0, 'h81, 0, 0};
        tbl[2]  = '{1, 3, 0, 1, 'h0F, 0, 0};
        tbl[3]  = '{0, 0, 'hB4, 0, 'hB4, 0, 0};
        tbl[4]  = '{4, 12, 0, 0, 'h4B, 0, 0};
        tbl[5]  = '{0, 0, 'h90, 0, 'h90, 0, 0};
        tbl[6]  = '{5, 2, 0, 0, 'hE4, 0, 0};
        tbl[7]  = '{2, 0, 0, 1, 'hE4, 0, 0};
        tbl[8]  = '{7, 5, 'h11, 0, 'hE4, 0, 1};
        tbl[9]  = '{3, 9, 0, 0, 'hC9, 1, 0};
        tbl[10] = '{2, 9, 0, 0, 'h00, 0, 0};
        tbl[11] = '{6, 0, 'h22, 0, 'h00, 0, 1};
        clear = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_cnt = '0;
        pdata_in = '0;
        sin = 1'b0;
        tick;
        tick;
        chk("reset_outputs", {pdata_out, sout, done, err, busy}, '0);
        clear = 1'b0;
        tick;
        chk("ready_after_reset", {cmd_ready, busy}, 2'b10);

        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].sv, e);
            chk($sformatf("tbl%0d_q", i), pdata_out, tbl[i].eq);
            chk($sformatf("tbl%0d_sout", i), sout, tbl[i].es);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].ee);
        end

        // cmd_valid held through SHIFT and DONE must not start a second command
        run_cmd(0, 0, 'h3C, 0, e);
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_cnt = C'(2);
        sin = 1'b0;
        tick;
        cmd_op = 3'd0;
        pdata_in = 'hFF;
        tick;
        tick;
        chk("hold_valid_done", done, 1);
        chk("hold_valid_q", pdata_out, 'hF0);
        cmd_valid = 1'b0;
        tick;
        chk("hold_valid_no_accept", {pdata_out, cmd_ready}, {8'hF0, 1'b1});
        mq = 'hF0;
        msout = 0;

        // Clear with two steps left aborts without a done pulse
        run_cmd(0, 0, 'hFF, 0, e);
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_cnt = C'(4);
        sin = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        chk("pre_clear_state", {pdata_out, sout, busy}, {8'hFF, 1'b1, 1'b1});
        clear = 1'b1;
        #1;
        chk("async_clear", {pdata_out, sout, done, busy, err}, '0);
        tick;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("post_clear_idle", {cmd_ready, done, pdata_out}, {1'b1, 1'b0, 8'h00});
        end
        mq = 0;
        msout = 0;

        for (int i = 0; i < 40; i++)
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 2 ** C - 1)), int'($urandom_range(0, 2 ** W - 1)), -1, e);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
